// File: rtl/cr_huf_comp_sort_sched_pkg.sv
// Shared types for the Huffman sorter scheduler: frame-type encoding, scheduler states, seq id width.
// CREOLE_HC_SEQID_WIDTH may be supplied by the surrounding build; a local default is provided.
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 8
`endif

package cr_huf_comp_sort_sched_pkg;

  typedef enum logic [1:0] {
    MIDDLE    = 2'd0,
    EOB       = 2'd1,
    PASS_THRU = 2'd2
  } e_pipe_eob;

  typedef enum logic {
    SS_IDLE = 1'b0,
    SS_BUSY = 1'b1
  } e_sort_sched_state;

  localparam int SEQID_W = `CREOLE_HC_SEQID_WIDTH;

endpackage

// File: rtl/cr_huf_comp_sort_sched_if.sv
// One requester's launch/handshake bundle; master = frequency-table producer, slave = scheduler.
interface cr_huf_comp_sort_sched_if
  import cr_huf_comp_sort_sched_pkg::*;
#(
  parameter int DAT_WIDTH        = 10,
  parameter int SYM_FREQ_WIDTH   = 15,
  parameter int CNTRL_WIDTH      = 1,
  parameter int MAX_NUM_SYM_USED = 576,
  parameter int CNT_WIDTH        = 16
);
  logic                                       valid;
  logic [MAX_NUM_SYM_USED*SYM_FREQ_WIDTH-1:0] new_freq;
  logic [CNTRL_WIDTH-1:0]                     meta;
  logic [SEQID_W-1:0]                         seq_id;
  e_pipe_eob                                  eob;
  logic [DAT_WIDTH-1:0]                       sym_lo;
  logic [DAT_WIDTH-1:0]                       sym_hi;
  logic                                       grant;
  logic                                       done;
  logic [CNT_WIDTH-1:0]                       done_cnt;

  modport master (
    output valid, new_freq, meta, seq_id, eob, sym_lo, sym_hi,
    input  grant, done, done_cnt
  );

  modport slave (
    input  valid, new_freq, meta, seq_id, eob, sym_lo, sym_hi,
    output grant, done, done_cnt
  );
endinterface

// File: rtl/cr_huf_comp_sort_sched_arb.sv
// 2-way launch arbiter. Round-robin when CR_HUF_SORT_SCHED_RR_EN is defined,
// otherwise fixed priority with req0 winning ties.
module cr_huf_comp_sort_sched_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] eligible,
  input  logic       advance,
  output logic       winner
);
`ifdef CR_HUF_SORT_SCHED_RR_EN
  logic last_q;

  // last_q resets to 1 so the first tie goes to req0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last_q <= 1'b1;
    else if (advance) last_q <= winner;
  end

  assign winner = (&eligible) ? ~last_q : eligible[1];
`else
  logic unused_arb;
  assign unused_arb = clk ^ rst_n ^ advance;
  assign winner     = ~eligible[0] & eligible[1];
`endif
endmodule

// File: rtl/cr_huf_comp_sort_sched.sv
// Shares one cr_huf_comp_is_sorter between two table producers: arbitrates frame launches,
// waits for sorter completion, returns done pulses and checks seq ids. Option: CR_HUF_SORT_SCHED_RR_EN.
module cr_huf_comp_sort_sched
  import cr_huf_comp_sort_sched_pkg::*;
#(
  parameter int DAT_WIDTH        = 10,
  parameter int SYM_FREQ_WIDTH   = 15,
  parameter int CNTRL_WIDTH      = 1,
  parameter int MAX_NUM_SYM_USED = 576,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  cr_huf_comp_sort_sched_if.slave                    req0,
  cr_huf_comp_sort_sched_if.slave                    req1,
  output logic [MAX_NUM_SYM_USED*SYM_FREQ_WIDTH-1:0] srt_new_freq,
  output logic [CNTRL_WIDTH-1:0]                     srt_meta,
  output logic [SEQID_W-1:0]                         srt_seq_id,
  output e_pipe_eob                                  srt_eob,
  output logic [DAT_WIDTH-1:0]                       srt_sym_lo,
  output logic [DAT_WIDTH-1:0]                       srt_sym_hi,
  input  logic                                       srt_not_ready,
  input  e_pipe_eob                                  srt_is_ht_eob,
  input  logic [SEQID_W-1:0]                         srt_is_ht_seq_id,
  output logic                                       busy,
  output logic                                       owner,
  output logic                                       err_seq_mismatch,
  output logic                                       err_bad_eob
);
  e_sort_sched_state    state_q;
  logic                 owner_q;
  logic [SEQID_W-1:0]   launched_seq_q;
  logic [CNT_WIDTH-1:0] done_cnt0_q;
  logic [CNT_WIDTH-1:0] done_cnt1_q;
  logic                 err_seq_q;
  logic                 err_eob_q;

  logic [1:0] eligible;
  logic       winner;
  logic       launch;
  logic       launch_out;
  logic       complete;
  logic       bad_eob;

  assign eligible = {req1.valid && (req1.eob != MIDDLE),
                     req0.valid && (req0.eob != MIDDLE)};
  assign bad_eob  = (req0.valid && (req0.eob == MIDDLE)) ||
                    (req1.valid && (req1.eob == MIDDLE));
  assign launch   = (state_q == SS_IDLE) && !srt_not_ready && (|eligible);
  // Visible launch is masked during reset; the flops are held by the async reset anyway
  assign launch_out = launch && rst_n;
  assign complete   = (state_q == SS_BUSY) && (srt_is_ht_eob != MIDDLE);

  cr_huf_comp_sort_sched_arb u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .eligible (eligible),
    .advance  (launch),
    .winner   (winner)
  );

  assign req0.grant    = launch_out && !winner;
  assign req1.grant    = launch_out &&  winner;
  assign req0.done     = complete && !owner_q;
  assign req1.done     = complete &&  owner_q;
  assign req0.done_cnt = done_cnt0_q;
  assign req1.done_cnt = done_cnt1_q;

  assign busy             = (state_q == SS_BUSY);
  assign owner            = owner_q;
  assign err_seq_mismatch = err_seq_q;
  assign err_bad_eob      = err_eob_q;

  always_comb begin
    srt_new_freq = '0;
    srt_meta     = '0;
    srt_seq_id   = '0;
    srt_eob      = MIDDLE;
    srt_sym_lo   = '0;
    srt_sym_hi   = '0;
    if (launch_out) begin
      if (winner) begin
        srt_new_freq = req1.new_freq;
        srt_meta     = req1.meta;
        srt_seq_id   = req1.seq_id;
        srt_eob      = req1.eob;
        srt_sym_lo   = req1.sym_lo;
        srt_sym_hi   = req1.sym_hi;
      end else begin
        srt_new_freq = req0.new_freq;
        srt_meta     = req0.meta;
        srt_seq_id   = req0.seq_id;
        srt_eob      = req0.eob;
        srt_sym_lo   = req0.sym_lo;
        srt_sym_hi   = req0.sym_hi;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= SS_IDLE;
      owner_q        <= 1'b0;
      launched_seq_q <= '0;
      done_cnt0_q    <= '0;
      done_cnt1_q    <= '0;
      err_seq_q      <= 1'b0;
      err_eob_q      <= 1'b0;
    end else begin
      case (state_q)
        SS_IDLE: begin
          if (launch) begin
            state_q        <= SS_BUSY;
            owner_q        <= winner;
            launched_seq_q <= winner ? req1.seq_id : req0.seq_id;
          end
        end
        SS_BUSY: begin
          if (complete) begin
            state_q <= SS_IDLE;
            if (owner_q) done_cnt1_q <= done_cnt1_q + CNT_WIDTH'(1);
            else         done_cnt0_q <= done_cnt0_q + CNT_WIDTH'(1);
            if (srt_is_ht_seq_id != launched_seq_q) err_seq_q <= 1'b1;
          end
        end
        default: state_q <= SS_IDLE;
      endcase
      if (bad_eob) err_eob_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cr_huf_comp_sort_sched.sv
// Scoreboard bench for cr_huf_comp_sort_sched with a behavioural sorter model;
// expected arbitration order follows CR_HUF_SORT_SCHED_RR_EN when defined.
module tb_cr_huf_comp_sort_sched;
  import cr_huf_comp_sort_sched_pkg::*;

  localparam int DW = 10, FW = 15, CW = 1, NS = 576, CNTW = 16, SW = SEQID_W;
  localparam int NFW = NS * FW;
  localparam int LAT = 6;
`ifdef CR_HUF_SORT_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [SW-1:0] seq;
    e_pipe_eob     eob;
    logic [DW-1:0] lo;
    logic [DW-1:0] hi;
    int            hold;
  } job_t;

  typedef struct {
    int   r;
    job_t j;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cr_huf_comp_sort_sched_if #(DW, FW, CW, NS, CNTW) req0_if ();
  cr_huf_comp_sort_sched_if #(DW, FW, CW, NS, CNTW) req1_if ();

  logic [NFW-1:0] srt_new_freq;
  logic [CW-1:0]  srt_meta;
  logic [SW-1:0]  srt_seq_id;
  e_pipe_eob      srt_eob;
  logic [DW-1:0]  srt_sym_lo, srt_sym_hi;
  logic           srt_not_ready;
  e_pipe_eob      srt_is_ht_eob;
  logic [SW-1:0]  srt_is_ht_seq_id;
  logic           busy, owner, err_seq_mismatch, err_bad_eob;

  cr_huf_comp_sort_sched #(
    .DAT_WIDTH(DW), .SYM_FREQ_WIDTH(FW), .CNTRL_WIDTH(CW),
    .MAX_NUM_SYM_USED(NS), .CNT_WIDTH(CNTW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0_if), .req1(req1_if),
    .srt_new_freq(srt_new_freq), .srt_meta(srt_meta), .srt_seq_id(srt_seq_id),
    .srt_eob(srt_eob), .srt_sym_lo(srt_sym_lo), .srt_sym_hi(srt_sym_hi),
    .srt_not_ready(srt_not_ready), .srt_is_ht_eob(srt_is_ht_eob),
    .srt_is_ht_seq_id(srt_is_ht_seq_id), .busy(busy), .owner(owner),
    .err_seq_mismatch(err_seq_mismatch), .err_bad_eob(err_bad_eob)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  exp_t exp_grant[$];
  int   exp_done[$];
  job_t jobq0[$];
  job_t jobq1[$];
  logic [CNTW-1:0] exp_cnt[2];
  int grant_cyc[2];
  int done_cyc[2];
  bit cnt_pend = 1'b0;
  int pend_r = 0;
  int m_last = 1;
  bit drv_busy0 = 1'b0, drv_busy1 = 1'b0;
  bit m_corrupt = 1'b0;
  int unsol_req = 0;

  function automatic logic [NFW-1:0] freq_of(input int r, input logic [SW-1:0] seq);
    logic [FW-1:0] f;
    f = FW'(int'(seq) * 37 + r * 11 + 1);
    return {NS{f}};
  endfunction

  task automatic set_req(input int r, input job_t j, input logic v);
    if (r == 0) begin
      req0_if.valid = v; req0_if.seq_id = j.seq; req0_if.eob = j.eob;
      req0_if.sym_lo = j.lo; req0_if.sym_hi = j.hi; req0_if.meta = j.seq[0];
      req0_if.new_freq = freq_of(0, j.seq);
    end else begin
      req1_if.valid = v; req1_if.seq_id = j.seq; req1_if.eob = j.eob;
      req1_if.sym_lo = j.lo; req1_if.sym_hi = j.hi; req1_if.meta = j.seq[0];
      req1_if.new_freq = freq_of(1, j.seq);
    end
  endtask

  // Requester driver: holds each job until granted (or for j.hold cycles), back-to-back
  task automatic drive_loop(input int r);
    job_t j;
    bit got;
    int k;
    j.seq = '0; j.eob = MIDDLE; j.lo = '0; j.hi = '0; j.hold = 0;
    set_req(r, j, 1'b0);
    forever begin
      @(posedge clk); #1;
      while ((r == 0) ? (jobq0.size() != 0) : (jobq1.size() != 0)) begin
        if (r == 0) begin j = jobq0.pop_front(); drv_busy0 = 1'b1; end
        else        begin j = jobq1.pop_front(); drv_busy1 = 1'b1; end
        set_req(r, j, 1'b1);
        if (j.hold > 0) begin
          repeat (j.hold) @(posedge clk);
          #1;
        end else begin
          got = 1'b0; k = 0;
          while (!got && k < 2000) begin
            @(negedge clk);
            got = (r == 0) ? req0_if.grant : req1_if.grant;
            k++;
          end
          @(posedge clk); #1;
        end
        set_req(r, j, 1'b0);
        if (r == 0) drv_busy0 = 1'b0; else drv_busy1 = 1'b0;
      end
    end
  endtask

  initial drive_loop(0);
  initial drive_loop(1);

  // Sorter model: captures a launch, raises not_ready, returns eob/seq LAT cycles later
  logic          l_seen = 1'b0;
  logic [SW-1:0] l_seq = '0;
  always @(negedge clk) begin
    l_seen = (srt_eob != MIDDLE);
    l_seq  = srt_seq_id;
  end

  initial begin : sorter_model
    int m_rem;
    int unsol_done;
    logic [SW-1:0] m_seq;
    m_rem = 0; unsol_done = 0; m_seq = '0;
    srt_not_ready = 1'b0; srt_is_ht_eob = MIDDLE; srt_is_ht_seq_id = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        m_rem = 0; srt_not_ready = 1'b0; srt_is_ht_eob = MIDDLE; srt_is_ht_seq_id = '0;
      end else if (srt_is_ht_eob != MIDDLE) begin
        srt_is_ht_eob = MIDDLE; srt_not_ready = 1'b0;
      end else if (unsol_req != unsol_done) begin
        srt_is_ht_eob = EOB; srt_is_ht_seq_id = '0; unsol_done = unsol_req;
      end else if (l_seen) begin
        m_rem = LAT - 1; srt_not_ready = 1'b1;
        m_seq = m_corrupt ? l_seq + SW'(1) : l_seq;
      end else if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          srt_is_ht_eob = EOB; srt_is_ht_seq_id = m_seq;
        end
      end
    end
  end

  // Monitor: grants and dones popped against the scoreboard queues
  initial begin : monitor
    logic [1:0] g, d;
    logic [CNTW-1:0] cnt;
    exp_t e;
    int r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt_pend = 1'b0;
      end else begin
        cyc++;
        if (cnt_pend) begin
          cnt = (pend_r == 1) ? req1_if.done_cnt : req0_if.done_cnt;
          n_cmp++;
          if (cnt !== exp_cnt[pend_r]) begin
            n_fail++;
            $display("FAIL done_cnt%0d: got %0d want %0d", pend_r, cnt, exp_cnt[pend_r]);
          end
          cnt_pend = 1'b0;
        end
        g = {req1_if.grant, req0_if.grant};
        n_cmp++;
        if (g == 2'b00) begin
          if (srt_eob !== MIDDLE) begin
            n_fail++;
            $display("FAIL idle_strobe: srt_eob %0d want MIDDLE (busy=%0b) cyc %0d", srt_eob, busy, cyc);
          end
        end else if (g == 2'b11 || exp_grant.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_grant: grants %b cyc %0d", g, cyc);
        end else begin
          e = exp_grant.pop_front();
          r = g[1] ? 1 : 0;
          if (r !== e.r || srt_seq_id !== e.j.seq || srt_eob !== e.j.eob ||
              srt_sym_lo !== e.j.lo || srt_sym_hi !== e.j.hi ||
              srt_meta !== e.j.seq[0] || srt_new_freq !== freq_of(e.r, e.j.seq)) begin
            n_fail++;
            $display("FAIL grant: req %0d seq %0h eob %0d want req %0d seq %0h eob %0d",
                     r, srt_seq_id, srt_eob, e.r, e.j.seq, e.j.eob);
          end
          grant_cyc[r] = cyc;
          exp_done.push_back(e.r);
        end
        d = {req1_if.done, req0_if.done};
        if (d != 2'b00) begin
          n_cmp++;
          if (d == 2'b11 || exp_done.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_done: dones %b cyc %0d", d, cyc);
          end else begin
            r = exp_done.pop_front();
            if (d !== ((r == 1) ? 2'b10 : 2'b01)) begin
              n_fail++;
              $display("FAIL done_owner: dones %b want req %0d", d, r);
            end
            done_cyc[r] = cyc;
            exp_cnt[r]  = exp_cnt[r] + CNTW'(1);
            pend_r = r; cnt_pend = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic launch(input int r, input logic [SW-1:0] seq, input e_pipe_eob eob,
                        input logic [DW-1:0] lo, input logic [DW-1:0] hi);
    job_t j;
    exp_t e;
    j.seq = seq; j.eob = eob; j.lo = lo; j.hi = hi; j.hold = 0;
    e.r = r; e.j = j;
    exp_grant.push_back(e);
    m_last = r;
    if (r == 0) jobq0.push_back(j); else jobq1.push_back(j);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    bit pending;
    k = 0;
    pending = 1'b1;
    while (pending && k < budget) begin
      @(negedge clk); #1;
      k++;
      pending = (exp_grant.size() != 0) || (exp_done.size() != 0) || (jobq0.size() != 0) ||
                (jobq1.size() != 0) || cnt_pend || drv_busy0 || drv_busy1 || busy;
    end
    n_cmp++;
    if (pending) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d grants and %0d dones outstanding after %0d cycles",
               name, exp_grant.size(), exp_done.size(), budget);
    end
  endtask

  task automatic wait_busy(input string name);
    int k;
    k = 0;
    while (!busy && k < 50) begin @(negedge clk); k++; end
    n_cmp++;
    if (!busy) begin
      n_fail++;
      $display("FAIL %s_busy: busy %0b want 1", name, busy);
    end
  endtask

  task automatic check_reset_vals(input string name);
    n_cmp++;
    if ({busy, owner, err_seq_mismatch, err_bad_eob, req0_if.grant, req1_if.grant,
         req0_if.done, req1_if.done} !== 8'h00 ||
        req0_if.done_cnt !== '0 || req1_if.done_cnt !== '0) begin
      n_fail++;
      $display("FAIL %s_ctrl: busy %b owner %b errs %b%b cnt %0d/%0d want all 0", name,
               busy, owner, err_seq_mismatch, err_bad_eob, req0_if.done_cnt, req1_if.done_cnt);
    end
    n_cmp++;
    if (srt_eob !== MIDDLE || srt_seq_id !== '0 || srt_sym_lo !== '0 || srt_sym_hi !== '0 ||
        srt_meta !== '0 || srt_new_freq !== '0) begin
      n_fail++;
      $display("FAIL %s_srt: eob %0d seq %0h want MIDDLE and zeros", name, srt_eob, srt_seq_id);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    exp_cnt[0] = '0; exp_cnt[1] = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_last = 1;
  endtask

  task automatic test_single_launch();
    launch(0, SW'(5), EOB, DW'(0), DW'(9));
    wait_drain("single", 100);
    n_cmp++;
    if (done_cyc[0] - grant_cyc[0] !== LAT) begin
      n_fail++;
      $display("FAIL single_latency: done-grant %0d want %0d", done_cyc[0] - grant_cyc[0], LAT);
    end
    n_cmp++;
    if (req0_if.done_cnt !== CNTW'(1) || err_seq_mismatch !== 1'b0 || err_bad_eob !== 1'b0 ||
        owner !== 1'b0) begin
      n_fail++;
      $display("FAIL single_state: cnt %0d errs %b%b owner %b want 1 00 0",
               req0_if.done_cnt, err_seq_mismatch, err_bad_eob, owner);
    end
  endtask

  task automatic test_tie();
    job_t j;
    exp_t e;
    int n0, n1, i0, i1, pick;
    n0 = 4; n1 = 2; i0 = 0; i1 = 0;
    while (n0 + n1 > 0) begin
      if (n0 > 0 && n1 > 0) pick = RR ? ((m_last == 0) ? 1 : 0) : 0;
      else                  pick = (n0 > 0) ? 0 : 1;
      e.r = pick;
      e.j.seq  = (pick == 0) ? SW'(8'h10 + i0) : SW'(8'h20 + i1);
      e.j.eob  = (pick == 0) ? EOB : PASS_THRU;
      e.j.lo   = DW'(pick * 100 + ((pick == 0) ? i0 : i1));
      e.j.hi   = DW'(575 - pick);
      e.j.hold = 0;
      exp_grant.push_back(e);
      m_last = pick;
      if (pick == 0) begin n0--; i0++; end else begin n1--; i1++; end
    end
    for (int i = 0; i < 4; i++) begin
      j.seq = SW'(8'h10 + i); j.eob = EOB; j.lo = DW'(i); j.hi = DW'(575); j.hold = 0;
      jobq0.push_back(j);
    end
    for (int i = 0; i < 2; i++) begin
      j.seq = SW'(8'h20 + i); j.eob = PASS_THRU; j.lo = DW'(100 + i); j.hi = DW'(574); j.hold = 0;
      jobq1.push_back(j);
    end
    wait_drain("tie", 400);
  endtask

  task automatic test_busy_block();
    launch(0, SW'(8'h30), EOB, DW'(1), DW'(2));
    wait_busy("block");
    @(negedge clk);
    launch(1, SW'(8'h31), PASS_THRU, DW'(3), DW'(4));
    wait_drain("block", 100);
    n_cmp++;
    if (grant_cyc[1] - done_cyc[0] !== 1) begin
      n_fail++;
      $display("FAIL block_gap: grant1-done0 %0d want 1", grant_cyc[1] - done_cyc[0]);
    end
  endtask

  task automatic test_seq_mismatch();
    m_corrupt = 1'b1;
    launch(0, SW'(3), EOB, DW'(5), DW'(6));
    wait_drain("seqmis", 100);
    m_corrupt = 1'b0;
    n_cmp++;
    if (err_seq_mismatch !== 1'b1) begin
      n_fail++;
      $display("FAIL seqmis_set: err_seq_mismatch %b want 1", err_seq_mismatch);
    end
    launch(1, SW'(7), EOB, DW'(7), DW'(8));
    wait_drain("seqmis2", 100);
    n_cmp++;
    if (err_seq_mismatch !== 1'b1) begin
      n_fail++;
      $display("FAIL seqmis_sticky: err_seq_mismatch %b want 1", err_seq_mismatch);
    end
  endtask

  task automatic test_bad_eob_unsol();
    job_t j;
    n_cmp++;
    if (err_bad_eob !== 1'b0) begin
      n_fail++;
      $display("FAIL badeob_pre: err_bad_eob %b want 0", err_bad_eob);
    end
    j.seq = SW'(8'h44); j.eob = MIDDLE; j.lo = '0; j.hi = '0; j.hold = 4;
    jobq1.push_back(j);
    repeat (8) @(negedge clk);
    n_cmp++;
    if (err_bad_eob !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL badeob_set: err_bad_eob %b busy %b want 1 0", err_bad_eob, busy);
    end
    unsol_req++;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (req0_if.done_cnt !== exp_cnt[0] || req1_if.done_cnt !== exp_cnt[1] || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL unsol_cnt: cnt %0d/%0d busy %b want %0d/%0d 0",
               req0_if.done_cnt, req1_if.done_cnt, busy, exp_cnt[0], exp_cnt[1]);
    end
  endtask

  task automatic test_reset_mid_frame();
    launch(0, SW'(8'h40), EOB, DW'(11), DW'(12));
    wait_busy("rstmid");
    @(posedge clk); #2;
    rst_n = 1'b0;
    exp_grant.delete();
    exp_done.delete();
    exp_cnt[0] = '0; exp_cnt[1] = '0;
    #1;
    check_reset_vals("rstmid");
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_last = 1;
    launch(0, SW'(8'h42), EOB, DW'(13), DW'(14));
    wait_drain("rstmid", 100);
    n_cmp++;
    if (req0_if.done_cnt !== CNTW'(1) || req1_if.done_cnt !== '0) begin
      n_fail++;
      $display("FAIL rstmid_cnt: cnt %0d/%0d want 1/0", req0_if.done_cnt, req1_if.done_cnt);
    end
  endtask

  initial begin
    grant_cyc[0] = 0; grant_cyc[1] = 0; done_cyc[0] = 0; done_cyc[1] = 0;
    test_reset();
    test_single_launch();
    test_tie();
    test_busy_block();
    test_seq_mismatch();
    test_bad_eob_unsol();
    test_reset_mid_frame();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
